// File: rtl/vend_pkg.sv
// Shared types and default parameters for the vending credit datapath.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, PAY, GAP} credit_state_t;

  localparam int DEF_NUM_COINS  = 3;
  localparam int DEF_CREDIT_W   = 8;
  localparam int DEF_MAX_CREDIT = 200;
  localparam int DEF_CHANGE_GAP = 4;

  localparam logic [DEF_CREDIT_W-1:0] COIN_5  = 8'd5;
  localparam logic [DEF_CREDIT_W-1:0] COIN_10 = 8'd10;
  localparam logic [DEF_CREDIT_W-1:0] COIN_25 = 8'd25;

  // Index 0 is the smallest denomination.
  localparam logic [DEF_NUM_COINS*DEF_CREDIT_W-1:0] DEF_COIN_VALUES = {COIN_25, COIN_10, COIN_5};

endpackage

// File: rtl/credit_manager_if.sv
// Coin, purchase and change signals between the front end / dispense controller and credit_manager.
interface credit_manager_if
  import vend_pkg::*;
#(
  parameter int NUM_COINS = DEF_NUM_COINS,
  parameter int CREDIT_W  = DEF_CREDIT_W
);
  logic [NUM_COINS-1:0] coin_in;
  logic [NUM_COINS-1:0] coin_reject;
  logic                 buy_req;
  logic [CREDIT_W-1:0]  price;
  logic                 buy_ack;
  logic                 buy_nack;
  logic                 refund_req;
  logic [NUM_COINS-1:0] change_out;
  logic                 busy;
  logic [CREDIT_W-1:0]  credit;

  modport master (
    output coin_in, buy_req, price, refund_req,
    input  coin_reject, buy_ack, buy_nack, change_out, busy, credit
  );

  modport slave (
    input  coin_in, buy_req, price, refund_req,
    output coin_reject, buy_ack, buy_nack, change_out, busy, credit
  );
endinterface

// File: rtl/coin_edge_detect.sv
// Registered rising-edge detector across all coin channels; a held-high level yields one event.
module coin_edge_detect #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] prev_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_reg <= '0;
    else       prev_reg <= level;
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rise
    assign rise[gi] = level[gi] & ~prev_reg[gi];
  end
endmodule

// File: rtl/credit_manager.sv
// Credit engine: coin acceptance with ceiling, purchase ack/nack and paced change payout.
module credit_manager
  import vend_pkg::*;
#(
  parameter int                            NUM_COINS   = DEF_NUM_COINS,
  parameter int                            CREDIT_W    = DEF_CREDIT_W,
  parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
  parameter int                            MAX_CREDIT  = DEF_MAX_CREDIT,
  parameter int                            CHANGE_GAP  = DEF_CHANGE_GAP
) (
  input logic             clk,
  input logic             reset,
  credit_manager_if.slave bus
);
  localparam int SUM_W = CREDIT_W + 1;
  localparam int GAP_W = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

  function automatic logic [CREDIT_W-1:0] coin_val(input int idx);
    return COIN_VALUES[idx*CREDIT_W +: CREDIT_W];
  endfunction

  credit_state_t        state_reg, state_next;
  logic [CREDIT_W-1:0]  credit_reg, credit_next;
  logic [GAP_W-1:0]     gap_cnt_reg, gap_cnt_next;
  logic [NUM_COINS-1:0] coin_reject_reg, coin_reject_next;
  logic [NUM_COINS-1:0] change_out_reg, change_out_next;
  logic                 buy_ack_reg, buy_ack_next;
  logic                 buy_nack_reg, buy_nack_next;

  logic [NUM_COINS-1:0] coin_evt;
  logic [SUM_W-1:0]     sum;
  logic [CREDIT_W-1:0]  pay_val;
  logic [NUM_COINS-1:0] pay_hot;

  coin_edge_detect #(.WIDTH(NUM_COINS)) u_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.coin_in),
    .rise  (coin_evt)
  );

  // Largest denomination that still fits in the current credit; none selected ends the payout.
  always_comb begin
    pay_val = '0;
    pay_hot = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (credit_reg >= coin_val(i)) begin
        pay_val = coin_val(i);
        pay_hot = NUM_COINS'(1) << i;
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    gap_cnt_next     = gap_cnt_reg;
    coin_reject_next = '0;
    change_out_next  = '0;
    buy_ack_next     = 1'b0;
    buy_nack_next    = 1'b0;
    sum              = {1'b0, credit_reg};

    case (state_reg)
      IDLE: begin
        // Purchase is deducted first; coins then accumulate on top in ascending channel order.
        if (bus.buy_req) begin
          if (bus.price <= credit_reg) begin
            sum          = sum - {1'b0, bus.price};
            buy_ack_next = 1'b1;
          end else begin
            buy_nack_next = 1'b1;
          end
        end
        for (int i = 0; i < NUM_COINS; i++) begin
          if (coin_evt[i]) begin
            if (sum + {1'b0, coin_val(i)} <= SUM_W'(MAX_CREDIT)) sum = sum + {1'b0, coin_val(i)};
            else coin_reject_next[i] = 1'b1;
          end
        end
        credit_next = sum[CREDIT_W-1:0];
        if (bus.refund_req && !bus.buy_req) state_next = PAY;
      end

      PAY: begin
        coin_reject_next = coin_evt;
        buy_nack_next    = bus.buy_req;
        if (pay_hot == '0) begin
          state_next = IDLE;
        end else begin
          change_out_next = pay_hot;
          credit_next     = credit_reg - pay_val;
          if (CHANGE_GAP == 0) begin
            state_next = PAY;
          end else begin
            state_next   = GAP;
            gap_cnt_next = GAP_W'(CHANGE_GAP - 1);
          end
        end
      end

      GAP: begin
        coin_reject_next = coin_evt;
        buy_nack_next    = bus.buy_req;
        if (gap_cnt_reg == '0) state_next = PAY;
        else                   gap_cnt_next = gap_cnt_reg - 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      credit_reg      <= '0;
      gap_cnt_reg     <= '0;
      coin_reject_reg <= '0;
      change_out_reg  <= '0;
      buy_ack_reg     <= 1'b0;
      buy_nack_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      gap_cnt_reg     <= gap_cnt_next;
      coin_reject_reg <= coin_reject_next;
      change_out_reg  <= change_out_next;
      buy_ack_reg     <= buy_ack_next;
      buy_nack_reg    <= buy_nack_next;
    end
  end

  assign bus.coin_reject = coin_reject_reg;
  assign bus.change_out  = change_out_reg;
  assign bus.buy_ack     = buy_ack_reg;
  assign bus.buy_nack    = buy_nack_reg;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.credit      = credit_reg;
endmodule
